fetch_queue_stage: RTL

Parametrised instruction-fetch stage and successor to the single-register fetch stage. Holds the PC and issues in-order requests to a pipelined instruction memory with arbitrary response latency. Buffers returned instructions in a QDEPTH-entry queue so decode stalls no longer freeze the memory. Handles jump/branch redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_queue_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - credit-limited instruction fetch stage with redirect flush (optional FETCH_PERF_CNT_EN perf counters)
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_valid,
    input  logic [XLEN-1:0]    jump_pc,
    input  logic               branch_valid,
    input  logic [XLEN-1:0]    branch_pc,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] QD_EXT = (CW+1)'(QDEPTH);

    logic [XLEN-1:0]    r_pc;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_out;
    logic [CW-1:0]      r_drop;
    logic [AW-1:0]      r_q_wr;
    logic [AW-1:0]      r_q_rd;
    logic [AW-1:0]      r_pf_wr;
    logic [AW-1:0]      r_pf_rd;
    logic [INSTR_W-1:0] r_q_instr [QDEPTH];
    logic [XLEN-1:0]    r_q_pc4   [QDEPTH];
    logic [XLEN-1:0]    r_pf_pc4  [QDEPTH];

    logic               w_redirect;
    logic [XLEN-1:0]    w_target;
    logic [CW:0]        w_credit_used;
    logic               w_accept;
    logic               w_resp;
    logic               w_drop_resp;
    logic               w_live_resp;
    logic               w_push;
    logic               w_pop;

    assign w_redirect    = jump_valid || branch_valid;
    assign w_target      = jump_valid ? jump_pc : branch_pc;
    // Stale in-flight responses still hold a credit until they come back.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_out};

    assign imem_req      = !rst && !w_redirect && (w_credit_used < QD_EXT);
    assign imem_addr     = r_pc;
    assign w_accept      = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp        = !rst && imem_rvalid && (r_out != '0);
    assign w_drop_resp   = w_resp && (r_drop != '0);
    assign w_live_resp   = w_resp && (r_drop == '0);
    assign w_push        = w_live_resp && !w_redirect;

    assign out_valid     = !rst && !w_redirect && (r_count != '0);
    assign w_pop         = out_valid && out_ready;
    assign out_instr     = (r_count != '0) ? r_q_instr[r_q_rd] : '0;
    assign out_pc_plus4  = (r_count != '0) ? r_q_pc4[r_q_rd] : '0;

    // PC, counters and queue pointers; a redirect turns every in-flight response stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_RESET;
            r_count <= '0;
            r_out   <= '0;
            r_drop  <= '0;
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_pf_wr <= '0;
            r_pf_rd <= '0;
        end else begin
            r_out <= r_out + CW'(w_accept) - CW'(w_resp);
            if (w_redirect) begin
                r_pc    <= w_target;
                r_count <= '0;
                r_drop  <= r_out - CW'(w_resp);
                r_q_wr  <= '0;
                r_q_rd  <= '0;
                r_pf_wr <= '0;
                r_pf_rd <= '0;
            end else begin
                if (w_accept) begin
                    r_pc    <= r_pc + XLEN'(4);
                    r_pf_wr <= r_pf_wr + AW'(1);
                end
                if (w_drop_resp) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_live_resp) begin
                    r_pf_rd <= r_pf_rd + AW'(1);
                end
                if (w_push) begin
                    r_q_wr <= r_q_wr + AW'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage arrays: PC FIFO captures PC+4 at accept, queue captures data with its PC+4.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pf_pc4[r_pf_wr] <= r_pc + XLEN'(4);
        end
        if (w_push) begin
            r_q_instr[r_q_wr] <= imem_rdata;
            r_q_pc4[r_q_wr]   <= r_pf_pc4[r_pf_rd];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] w_flush_inc;

    assign w_flush_inc  = 32'(w_drop_resp || (w_resp && w_redirect))
                        + (w_redirect ? 32'(r_count) : 32'd0);
    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;

    // Count delivered instructions and discarded work (stale responses plus flushed entries).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_pop);
            r_perf_flushed <= r_perf_flushed + w_flush_inc;
        end
    end
`endif

endmodule
